// File: rtl/msg_receiver.sv
// Receive-side message assembler: packs a byte stream into a 16-character buffer,
// closes on terminator or full buffer, holds until acknowledged, drops stale partials.
module msg_receiver #(
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [7:0] TERM_BYTE      = 8'h0A,
    parameter logic [7:0] FILL_BYTE      = 8'h20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         msg_ack,
    input  logic [3:0]   char_addr,
    output logic         rx_ready,
    output logic [127:0] msg,
    output logic [4:0]   msg_len,
    output logic         msg_valid,
    output logic         rx_error,
    output logic [7:0]   char_out
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [127:0]   r_msg;
    logic [127:0]   w_msg_next;
    logic [4:0]     r_len;
    logic [4:0]     w_len_next;
    logic [TW-1:0]  r_timer;
    logic           r_err;
    logic           w_accept;
    logic           w_term;
    logic           w_store;
    logic           w_timeout;
    logic           w_clear;
    logic [7:0]     w_chars [16];

    assign w_accept  = rx_valid && rx_ready;
    assign w_term    = (rx_data == TERM_BYTE);
    assign w_store   = w_accept && !w_term;
    // A byte arriving on the timeout cycle keeps the message alive.
    assign w_timeout = (r_state == S_RECV) && !w_accept && (r_timer == TMR_LAST);
    assign w_clear   = w_timeout || ((r_state == S_DONE) && msg_ack);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            assign w_msg_next[127-8*gi -: 8] =
                w_clear                           ? FILL_BYTE :
                (w_store && (r_len == 5'(gi)))    ? rx_data   :
                                                    r_msg[127-8*gi -: 8];
            assign w_chars[gi] = r_msg[127-8*gi -: 8];
        end
    endgenerate

    assign w_len_next = w_clear ? 5'd0 : (w_store ? r_len + 5'd1 : r_len);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_store) w_state_next = S_RECV;
            S_RECV: begin
                if ((w_store && (r_len == 5'd15)) || (w_accept && w_term))
                    w_state_next = S_DONE;
                else if (w_timeout)
                    w_state_next = S_IDLE;
            end
            S_DONE: if (msg_ack) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = (r_state != S_DONE);
        msg_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg   <= {16{FILL_BYTE}};
            r_len   <= 5'd0;
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_msg <= w_msg_next;
            r_len <= w_len_next;
            r_err <= w_timeout;
            // Idle counter only runs while a partial message is pending; saturates.
            if ((r_state != S_RECV) || w_accept)
                r_timer <= '0;
            else if (r_timer != TMR_MAX)
                r_timer <= r_timer + 1'b1;
        end
    end

    assign msg      = r_msg;
    assign msg_len  = r_len;
    assign rx_error = r_err;
    assign char_out = w_chars[char_addr];

endmodule

// File: tb/tb_msg_receiver.sv
// Bench for msg_receiver: directed scenarios plus randomized traffic checked
// against a queue-based message model.
module tb_msg_receiver;

    localparam int T = 1000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         msg_ack = 1'b0;
    logic [3:0]   char_addr = 4'd0;
    logic         rx_ready;
    logic [127:0] msg;
    logic [4:0]   msg_len;
    logic         msg_valid;
    logic         rx_error;
    logic [7:0]   char_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_q[$];
    bit         m_done = 1'b0;
    int         m_idle = 0;
    bit         m_err  = 1'b0;

    localparam logic [127:0] ALL_FILL = {16{8'h20}};

    msg_receiver #(.TIMEOUT_CYCLES(T), .TERM_BYTE(8'h0A), .FILL_BYTE(8'h20)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .msg_ack(msg_ack), .char_addr(char_addr), .rx_ready(rx_ready),
        .msg(msg), .msg_len(msg_len), .msg_valid(msg_valid),
        .rx_error(rx_error), .char_out(char_out)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] model_msg();
        logic [127:0] m;
        for (int i = 0; i < 16; i++)
            m[127-8*i -: 8] = (i < m_q.size()) ? m_q[i] : 8'h20;
        return m;
    endfunction

    function automatic logic [7:0] model_char(input logic [3:0] a);
        return (int'(a) < m_q.size()) ? m_q[a] : 8'h20;
    endfunction

    // Advance one edge with the given inputs, updating the model from the rules.
    task automatic tick(input logic v, input logic [7:0] d, input logic a, input logic r);
        rx_valid = v; rx_data = d; msg_ack = a; rst = r;
        @(posedge clk);
        m_err = 1'b0;
        if (r) begin
            m_q.delete(); m_done = 1'b0; m_idle = 0;
        end else if (m_done) begin
            if (a) begin
                m_q.delete(); m_done = 1'b0; m_idle = 0;
                $display("ack message");
            end
        end else if (v) begin
            m_idle = 0;
            if (d == 8'h0A) begin
                if (m_q.size() > 0) m_done = 1'b1;
                $display("rx terminator len=%0d", m_q.size());
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 16) m_done = 1'b1;
                $display("rx byte %h len=%0d", d, m_q.size());
            end
        end else if (m_q.size() > 0) begin
            if (m_idle == T - 1) begin
                m_q.delete(); m_err = 1'b1; m_idle = 0;
                $display("timeout discard");
            end else begin
                m_idle++;
            end
        end
        #1;
        rx_valid = 1'b0; msg_ack = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", rx_ready); end
        total++; if (msg !== ALL_FILL) begin bad++; $display("FAIL reset_msg got=%h exp=%h", msg, ALL_FILL); end
        total++; if (msg_len !== 5'd0) begin bad++; $display("FAIL reset_len got=%0d exp=0", msg_len); end
        total++; if (msg_valid !== 1'b0 || rx_error !== 1'b0) begin bad++; $display("FAIL reset_flags got valid=%b err=%b exp=0/0", msg_valid, rx_error); end
        total++; if (char_out !== 8'h20) begin bad++; $display("FAIL reset_char got=%h exp=20", char_out); end
    endtask

    task automatic test_911();
        logic [7:0] s [4] = '{8'h39, 8'h31, 8'h31, 8'h0A};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, s[i], 1'b0, 1'b0);
            if (i < 3) begin tick(1'b0, 8'h00, 1'b0, 1'b0); tick(1'b0, 8'h00, 1'b0, 1'b0); end
        end
        total++; if (msg !== {24'h393131, {13{8'h20}}}) begin bad++; $display("FAIL 911_msg got=%h", msg); end
        total++; if (msg_len !== 5'd3) begin bad++; $display("FAIL 911_len got=%0d exp=3", msg_len); end
        total++; if (msg_valid !== 1'b1 || rx_ready !== 1'b0) begin bad++; $display("FAIL 911_done got valid=%b ready=%b exp=1/0", msg_valid, rx_ready); end
        char_addr = 4'd1; #1;
        total++; if (char_out !== 8'h31) begin bad++; $display("FAIL 911_char got=%h exp=31", char_out); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (msg !== ALL_FILL || msg_len !== 5'd0 || rx_ready !== 1'b1 || msg_valid !== 1'b0)
            begin bad++; $display("FAIL 911_ack got len=%0d ready=%b valid=%b msg=%h", msg_len, rx_ready, msg_valid, msg); end
    endtask

    task automatic test_full();
        logic [127:0] exp_msg = "ABCDEFGHIJKLMNOP";
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
        total++; if (msg !== exp_msg) begin bad++; $display("FAIL full_msg got=%h exp=%h", msg, exp_msg); end
        total++; if (msg_len !== 5'd16 || msg_valid !== 1'b1 || rx_ready !== 1'b0)
            begin bad++; $display("FAIL full_state got len=%0d valid=%b ready=%b exp=16/1/0", msg_len, msg_valid, rx_ready); end
        tick(1'b1, 8'h51, 1'b0, 1'b0);
        total++; if (msg !== exp_msg || msg_len !== 5'd16) begin bad++; $display("FAIL full_17th got len=%0d msg=%h", msg_len, msg); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int err_cycle = -1;
        int err_count = 0;
        tick(1'b1, 8'h35, 1'b0, 1'b0);
        for (int k = 1; k <= T + 2; k++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            if (rx_error === 1'b1) begin err_count++; err_cycle = k; end
            if (k == T) begin
                total++; if (msg_len !== 5'd0 || msg !== ALL_FILL) begin bad++; $display("FAIL timeout_clear got len=%0d msg=%h", msg_len, msg); end
            end
        end
        total++; if (err_count != 1 || err_cycle != T) begin bad++; $display("FAIL timeout_pulse got count=%0d cycle=%0d exp=1/%0d", err_count, err_cycle, T); end
        // Second byte lands on the edge that would otherwise time out.
        err_count = 0;
        tick(1'b1, 8'h35, 1'b0, 1'b0);
        for (int k = 1; k < T; k++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            if (rx_error === 1'b1) err_count++;
        end
        tick(1'b1, 8'h36, 1'b0, 1'b0);
        if (rx_error === 1'b1) err_count++;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        if (rx_error === 1'b1) err_count++;
        total++; if (msg_len !== 5'd2 || msg[127:112] !== 16'h3536 || err_count != 0)
            begin bad++; $display("FAIL timeout_save got len=%0d top=%h errs=%0d exp=2/3536/0", msg_len, msg[127:112], err_count); end
        tick(1'b1, 8'h0A, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_edges();
        tick(1'b1, 8'h0A, 1'b0, 1'b0);
        total++; if (msg_len !== 5'd0 || rx_ready !== 1'b1 || msg_valid !== 1'b0)
            begin bad++; $display("FAIL idle_term got len=%0d ready=%b valid=%b", msg_len, rx_ready, msg_valid); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (msg_len !== 5'd0 || msg !== ALL_FILL || rx_ready !== 1'b1)
            begin bad++; $display("FAIL idle_ack got len=%0d ready=%b", msg_len, rx_ready); end
        tick(1'b1, 8'h61, 1'b0, 1'b0);
        tick(1'b1, 8'h62, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (msg_len !== 5'd0 || msg !== ALL_FILL || rx_ready !== 1'b1 || msg_valid !== 1'b0 || rx_error !== 1'b0)
            begin bad++; $display("FAIL mid_reset got len=%0d ready=%b valid=%b err=%b", msg_len, rx_ready, msg_valid, rx_error); end
    endtask

    task automatic test_random();
        logic       v, a;
        logic [7:0] d;
        for (int c = 0; c < 400; c++) begin
            v = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
            a = ($urandom_range(0, 4) == 0);
            char_addr = 4'($urandom_range(0, 15));
            tick(v, d, a, 1'b0);
            total++; if (msg !== model_msg()) begin bad++; $display("FAIL rand_msg c=%0d got=%h exp=%h", c, msg, model_msg()); end
            total++; if (msg_len !== 5'(m_q.size())) begin bad++; $display("FAIL rand_len c=%0d got=%0d exp=%0d", c, msg_len, m_q.size()); end
            total++; if (msg_valid !== m_done || rx_ready !== !m_done) begin bad++; $display("FAIL rand_hs c=%0d got valid=%b ready=%b exp done=%b", c, msg_valid, rx_ready, m_done); end
            total++; if (rx_error !== m_err) begin bad++; $display("FAIL rand_err c=%0d got=%b exp=%b", c, rx_error, m_err); end
            total++; if (char_out !== model_char(char_addr)) begin bad++; $display("FAIL rand_char c=%0d got=%h exp=%h", c, char_out, model_char(char_addr)); end
        end
    endtask

    initial begin
        test_reset();
        test_911();
        test_full();
        test_timeout();
        test_edges();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_receiver.md
# msg_receiver

Receive-side message assembler for the keypad messaging link. It accepts the byte stream produced by the transmit path (one byte per strobe) and packs it into a 16-character, 128-bit message buffer. It detects end-of-message by a terminator byte or a full buffer, and holds the completed message for a downstream consumer (display driver) until that consumer acknowledges it. An inter-byte timeout discards partial messages.

## Interface
- TIMEOUT_CYCLES, 1000: max idle cycles between accepted bytes within a message before the partial message is discarded
- TERM_BYTE, 8'h0A: end-of-message byte; never stored
- FILL_BYTE, 8'h20: value of unused character slots

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  byte strobe; byte is accepted on an edge where rx_valid && rx_ready
- msg_ack  in  1  consumer has taken the message; honoured only in DONE
- char_addr  in  4  character index for char_out (0 = first received)
- rx_ready  out  1  block can accept a byte (high in IDLE/RECV)
- msg  out  128  message buffer; char i at msg[127-8i -: 8]
- msg_len  out  5  number of stored characters, 0..16
- msg_valid  out  1  high while in DONE
- rx_error  out  1  one-cycle pulse on timeout discard
- char_out  out  8  combinational msg[127-8*char_addr -: 8]

## Operation
- States: IDLE (no chars stored), RECV (1..15 chars stored), DONE (message complete).
- IDLE: rx_ready=1. On an accepted byte other than TERM_BYTE, store it at index 0, set msg_len=1, clear timer, go to RECV. An accepted TERM_BYTE is dropped (no empty messages) and the state stays IDLE.
- RECV: rx_ready=1, timer increments each cycle.
  - Accepted byte other than TERM_BYTE: store at index msg_len, increment msg_len, clear timer. If msg_len becomes 16, go to DONE.
  - Accepted TERM_BYTE: go to DONE. The byte is not stored and msg_len is unchanged.
  - No byte, timer == TIMEOUT_CYCLES-1: pulse rx_error, refill msg with FILL_BYTE, set msg_len=0, go to IDLE.
  - Byte accepted on the timeout cycle: the byte wins, with no error.
- DONE: rx_ready=0, msg_valid=1, msg/msg_len frozen, rx_valid ignored (bytes dropped). On msg_ack, refill msg with FILL_BYTE, set msg_len=0, go to IDLE.
- msg_ack outside DONE is ignored.
- msg is all FILL_BYTE whenever in IDLE. Slots at index >= msg_len always hold FILL_BYTE.
- Timer width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- msg_len never exceeds 16. A 17th byte cannot be accepted because rx_ready=0 in DONE.

## Timing
- Reset values (asserted on the edge with rst=1, highest priority, any state):
  - state IDLE, rx_ready=1
  - msg all FILL_BYTE, msg_len=0
  - msg_valid=0, rx_error=0, timer=0
  - char_out=FILL_BYTE
- Byte accepted at edge N: msg/msg_len updated and visible after edge N (1-cycle latency).
- msg_valid rises after the edge accepting the 16th character or the terminator. rx_ready falls on that same edge.
- msg_ack sampled at edge M in DONE: after edge M, msg_valid=0, rx_ready=1, msg cleared. A byte presented the cycle after M is accepted.
- rx_error is high for exactly the one cycle following the timeout edge. It coincides with the first IDLE cycle.
- Reset mid-RECV or mid-DONE discards all content immediately; no rx_error.
- char_out is combinational from msg and char_addr, with no added latency.

## Test plan
- Reset: hold rst 3 cycles -> rx_ready=1, msg=all 8'h20, msg_len=0, msg_valid=0, rx_error=0.
- "911" then 8'h0A, one byte every 3 cycles:
  - msg[127:104]=24'h393131, rest 8'h20, msg_len=3
  - msg_valid high the cycle after the terminator
  - char_addr=1 -> char_out=8'h31
  - msg_ack -> msg cleared, msg_len=0, rx_ready=1 next cycle
- Full buffer: 16 back-to-back bytes 8'h41..8'h50 with no terminator:
  - msg=ASCII "ABCDEFGHIJKLMNOP", msg_len=16, msg_valid=1, rx_ready=0 after the 16th
  - 17th byte 8'h51 with rx_valid ignored, msg unchanged
- Timeout: byte 8'h35, then idle:
  - rx_error pulses exactly TIMEOUT_CYCLES cycles after acceptance; msg_len=0, msg all 8'h20
  - repeat with a second byte on cycle TIMEOUT_CYCLES-1 -> accepted, msg_len=2, no rx_error
- Edge cases:
  - 8'h0A while IDLE -> ignored, msg_len stays 0
  - msg_ack in IDLE -> no effect
  - rst asserted after 2 bytes in RECV -> reset values next cycle, no rx_error
